tile_game_ctrl: RTL and testbench
=================================

Name: tile_game_ctrl

Overview:
- Sequencer for the 7-row falling-tile datapath (`shiftrow`).
- Generates the row-shift tempo and judges player key presses against the bottom row (lane code 1..4, 0 = empty).
- Drives the datapath's `shift`, `correct_input` and row-clear controls; keeps score, miss count and speed level.
- Sits between the debounced key inputs and `shiftrow`; the display and score blocks read its outputs.

Parameters:
- TICK_START, 25000000: initial shift period in clk cycles.
- TICK_STEP, 2000000: period reduction per speed level.
- TICK_MIN, 5000000: lower bound on the period.
- HITS_PER_LEVEL, 8: correct hits between speed-ups.
- MAX_MISSES, 3: miss count that ends the game.
- SCORE_W, 10: score counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; a rising edge starts a game from IDLE or OVER
- key  in  4  synchronized key levels; key[i] selects lane code i+1
- bottom_line  in  3  current `line_6` from `shiftrow`
- shift  out  1  one-cycle shift pulse to `shiftrow`
- correct_input  out  1  one-cycle clear-bottom pulse to `shiftrow`
- row_clear  out  1  one-cycle pulse; the top level drives `shiftrow` `resetn` low with it
- score  out  SCORE_W  correct hits, saturating at all-ones
- misses  out  2  miss count
- level  out  4  speed level, saturating at 15
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER

Behaviour:
- Reset: state=IDLE, all outputs 0, period=TICK_START, tick counter=0, key/start edge registers=0, pending flags=0.
- States:
  - IDLE -> PLAY on start rising edge.
  - PLAY -> OVER when misses reaches MAX_MISSES. The transition happens in the cycle after the miss register update.
  - OVER -> PLAY on start rising edge.
- Entering PLAY (one cycle):
  - row_clear=1.
  - score, misses, level, tick counter and pending flags cleared; period=TICK_START.
- Tick counter:
  - Counts only in PLAY.
  - When it reaches period-1 it wraps to 0 and raises a shift request.
- Key events:
  - Event = rising edge of key (key & ~key_q).
  - Zero edges in a cycle: no event.
  - More than one edge in the same cycle: one wrong event.
- Judging a single event (uses bottom_line in the judging cycle):
  - bottom_line==0: ignored.
  - bottom_line==i+1: hit. correct_input=1, score+1 (saturating). The hit counter advances; on reaching HITS_PER_LEVEL it resets to 0, level+1 (saturating) and period -= TICK_STEP, clamped at TICK_MIN.
  - Any other value: miss, misses+1.
- Shift issue: when a shift request is issued, shift=1. If bottom_line!=0 in that cycle, the tile falls off: misses+1.
- Mutual exclusion: `shiftrow` gives `correct_input` priority over `shift`, so shift and correct_input are never high in the same cycle.
  - Hit and shift request in the same cycle: correct_input wins; the shift is held in shift_pend and issued the next cycle.
  - shift_pend then sees the already-cleared bottom_line (1-cycle datapath latency), so no false miss.
- Key in the cycle shift=1: the event is held in key_pend and judged the next cycle against the post-shift bottom_line.
- One miss per cycle max: a wrong key and a fall-off in the same cycle count as one miss.
- misses saturates at MAX_MISSES.
- Outside PLAY: shift=correct_input=0; keys and tick are ignored.
- reset asserted mid-game returns to IDLE next edge with reset values; no row_clear pulse.
- Output timing: shift, correct_input and row_clear are registered one-cycle pulses. score, misses and level are registered and update on the edge following the judging cycle.

Decomposition:
- Package tile_game_pkg: state enum {IDLE, PLAY, OVER}, LANE_EMPTY=3'd0, lane-code constants 1..4, MISS_W=2.
- One sub-module: tile_tempo_gen. It holds the tick counter, period register and level logic; inputs level_up and restart, output shift_req.
- FSM, key edge detect, judging and counters stay in tile_game_ctrl.

Test Plan:
- TICK_START=8, reset 2 cycles, start edge -> row_clear one cycle, playing=1, first shift pulse 8 cycles later, then every 8 cycles.
- bottom_line=3, key[2] edge -> correct_input one cycle later, score=1, misses=0; bottom_line=3, key[0] edge -> misses=1, no correct_input.
- bottom_line=2 held across a shift pulse with no key -> misses increments at the shift; after 3 such shifts -> game_over=1, playing=0, no further shift pulses.
- Hit edge in the same cycle as a tick wrap -> correct_input in cycle N, shift in cycle N+1, never overlapping, no extra miss.
- HITS_PER_LEVEL=2, TICK_STEP=2, TICK_MIN=4, 6 hits -> level=3, shift interval 8 -> 6 -> 4 -> 4.
- key[0] and key[1] rising together with bottom_line=1 -> one miss, score unchanged; reset mid-PLAY -> IDLE, all outputs 0.

Source files
------------

// File: rtl/tile_game_pkg.sv
// ----------------------------------------------------------------------------
// tile_game_pkg : shared state encoding and lane codes for the tile game
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tile_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [2:0] LANE_EMPTY = 3'd0;
  localparam logic [2:0] LANE_1     = 3'd1;
  localparam logic [2:0] LANE_2     = 3'd2;
  localparam logic [2:0] LANE_3     = 3'd3;
  localparam logic [2:0] LANE_4     = 3'd4;

  localparam int MISS_W = 2;

  // Key mask that a player must press to hit the given lane; codes 5..7 match nothing.
  function automatic logic [3:0] lane_onehot(input logic [2:0] lane);
    logic [3:0] mask;
    case (lane)
      LANE_1:  mask = 4'b0001;
      LANE_2:  mask = 4'b0010;
      LANE_3:  mask = 4'b0100;
      LANE_4:  mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_tempo_gen.sv
// ----------------------------------------------------------------------------
// tile_tempo_gen : row-shift tick counter, shift period and speed level
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tile_tempo_gen #(
  parameter int unsigned TICK_START = 25000000,
  parameter int unsigned TICK_STEP  = 2000000,
  parameter int unsigned TICK_MIN   = 5000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic       restart_i,
  input  logic       level_up_i,
  output logic       shift_req_o,
  output logic [3:0] level_o
);

  localparam int CNT_W = $clog2(TICK_START + 1);
  localparam logic [CNT_W-1:0] START_C = CNT_W'(TICK_START);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(TICK_STEP);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(TICK_MIN);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       level_q, level_d;

  // >= rather than == so a period that shrinks below the running count still wraps.
  assign shift_req_o = run_i && (tick_q >= (period_q - CNT_W'(1)));
  assign level_o     = level_q;

  always_comb begin
    tick_d   = tick_q;
    period_d = period_q;
    level_d  = level_q;
    if (restart_i) begin
      tick_d   = '0;
      period_d = START_C;
      level_d  = '0;
    end else begin
      if (run_i) begin
        tick_d = shift_req_o ? '0 : tick_q + CNT_W'(1);
      end
      if (level_up_i) begin
        level_d = (level_q == 4'hF) ? level_q : level_q + 4'd1;
        if ({1'b0, period_q} >= ({1'b0, MIN_C} + {1'b0, STEP_C})) begin
          period_d = period_q - STEP_C;
        end else begin
          period_d = MIN_C;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q   <= '0;
      period_q <= START_C;
      level_q  <= '0;
    end else begin
      tick_q   <= tick_d;
      period_q <= period_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_game_ctrl.sv
// ----------------------------------------------------------------------------
// tile_game_ctrl : game FSM, key judging against the bottom row, score/misses
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tile_game_ctrl
  import tile_game_pkg::*;
#(
  parameter int unsigned TICK_START     = 25000000,
  parameter int unsigned TICK_STEP      = 2000000,
  parameter int unsigned TICK_MIN       = 5000000,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned MAX_MISSES     = 3,
  parameter int unsigned SCORE_W        = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [3:0]         key_i,
  input  logic [2:0]         bottom_line_i,
  output logic               shift_o,
  output logic               correct_input_o,
  output logic               row_clear_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [MISS_W-1:0]  misses_o,
  output logic [3:0]         level_o,
  output logic               playing_o,
  output logic               game_over_o
);

  localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [3:0]           key_q;
  logic [3:0]           key_pend_q, key_pend_d;
  logic                 shift_pend_q, shift_pend_d;
  logic                 shift_q, shift_d;
  logic                 corr_q, corr_d;
  logic                 row_clear_q, row_clear_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MISS_W-1:0]    misses_q, misses_d;
  logic [HIT_W-1:0]     hits_q, hits_d;

  logic       start_edge, miss_lim, run, restart, level_up, shift_req;
  logic [3:0] key_edge, ev;
  logic       multi, bl_nz, judge, hit, wrong, fall;

  assign start_edge = start_i & ~start_q;
  assign key_edge   = key_i & ~key_q;
  assign ev         = key_pend_q | key_edge;
  assign multi      = |(ev & (ev - 4'd1));
  assign bl_nz      = (bottom_line_i != LANE_EMPTY);
  assign miss_lim   = (misses_q >= MISS_W'(MAX_MISSES));
  assign run        = (state_q == PLAY) && !miss_lim;
  assign restart    = (state_q != PLAY) && start_edge;

  tile_tempo_gen #(
    .TICK_START (TICK_START),
    .TICK_STEP  (TICK_STEP),
    .TICK_MIN   (TICK_MIN)
  ) u_tempo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .run_i       (run),
    .restart_i   (restart),
    .level_up_i  (level_up),
    .shift_req_o (shift_req),
    .level_o     (level_o)
  );

  always_comb begin
    state_d      = state_q;
    key_pend_d   = key_pend_q;
    shift_pend_d = shift_pend_q;
    shift_d      = 1'b0;
    corr_d       = 1'b0;
    row_clear_d  = 1'b0;
    score_d      = score_q;
    misses_d     = misses_q;
    hits_d       = hits_q;
    level_up     = 1'b0;
    judge        = 1'b0;
    hit          = 1'b0;
    wrong        = 1'b0;
    fall         = 1'b0;
    case (state_q)
      PLAY: begin
        if (miss_lim) begin
          state_d      = OVER;
          key_pend_d   = '0;
          shift_pend_d = 1'b0;
        end else begin
          // Keys seen while a shift is in flight wait one cycle for the new bottom row.
          if (shift_q) begin
            key_pend_d = ev;
          end else begin
            key_pend_d = '0;
            judge      = |ev;
          end
          hit   = judge && bl_nz && !multi && (ev == lane_onehot(bottom_line_i));
          wrong = judge && bl_nz && !hit;
          if (hit) begin
            corr_d       = 1'b1;
            score_d      = (&score_q) ? score_q : score_q + SCORE_W'(1);
            shift_pend_d = shift_req | shift_pend_q;
            if (hits_q == HIT_W'(HITS_PER_LEVEL - 1)) begin
              hits_d   = '0;
              level_up = 1'b1;
            end else begin
              hits_d = hits_q + HIT_W'(1);
            end
          end else begin
            shift_d      = shift_req | shift_pend_q;
            shift_pend_d = 1'b0;
            // A deferred shift follows a hit, so the bottom row it drops is already cleared.
            fall         = shift_req && !shift_pend_q && bl_nz;
          end
          if (wrong || fall) begin
            misses_d = misses_q + MISS_W'(1);
          end
        end
      end
      default: begin
        if (start_edge) begin
          state_d      = PLAY;
          row_clear_d  = 1'b1;
          score_d      = '0;
          misses_d     = '0;
          hits_d       = '0;
          key_pend_d   = '0;
          shift_pend_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      key_q        <= '0;
      key_pend_q   <= '0;
      shift_pend_q <= 1'b0;
      shift_q      <= 1'b0;
      corr_q       <= 1'b0;
      row_clear_q  <= 1'b0;
      score_q      <= '0;
      misses_q     <= '0;
      hits_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_i;
      key_q        <= key_i;
      key_pend_q   <= key_pend_d;
      shift_pend_q <= shift_pend_d;
      shift_q      <= shift_d;
      corr_q       <= corr_d;
      row_clear_q  <= row_clear_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      hits_q       <= hits_d;
    end
  end

  assign shift_o         = shift_q;
  assign correct_input_o = corr_q;
  assign row_clear_o     = row_clear_q;
  assign score_o         = score_q;
  assign misses_o        = misses_q;
  assign playing_o       = (state_q == PLAY);
  assign game_over_o     = (state_q == OVER);

endmodule

`default_nettype wire

// File: tb/tb_tile_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tile_game_ctrl : scoreboard bench for tile_game_ctrl with a short tempo
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tile_game_ctrl;

  localparam int SCORE_W = 10;

  typedef struct packed {
    logic               sh;
    logic               co;
    logic               rc;
    logic [SCORE_W-1:0] sc;
    logic [1:0]         mi;
    logic [3:0]         lv;
    logic               pl;
    logic               ov;
  } snap_t;

  typedef struct packed {
    int    cyc;
    snap_t s;
  } exp_t;

  logic               clk    = 1'b0;
  logic               reset  = 1'b1;
  logic               start  = 1'b0;
  logic [3:0]         key    = 4'd0;
  logic [2:0]         bottom = 3'd0;
  logic               shift_o, correct_input_o, row_clear_o, playing_o, game_over_o;
  logic [SCORE_W-1:0] score_o;
  logic [1:0]         misses_o;
  logic [3:0]         level_o;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  tile_game_ctrl #(
    .TICK_START     (8),
    .TICK_STEP      (2),
    .TICK_MIN       (4),
    .HITS_PER_LEVEL (2),
    .MAX_MISSES     (3),
    .SCORE_W        (SCORE_W)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .key_i           (key),
    .bottom_line_i   (bottom),
    .shift_o         (shift_o),
    .correct_input_o (correct_input_o),
    .row_clear_o     (row_clear_o),
    .score_o         (score_o),
    .misses_o        (misses_o),
    .level_o         (level_o),
    .playing_o       (playing_o),
    .game_over_o     (game_over_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic void exp_ev(input int c, input bit sh, input bit co, input bit rc,
                                 input int sc, input int mi, input int lv,
                                 input bit pl, input bit ov);
    exp_t e;
    e.cyc  = c;
    e.s.sh = sh;
    e.s.co = co;
    e.s.rc = rc;
    e.s.sc = SCORE_W'(sc);
    e.s.mi = 2'(mi);
    e.s.lv = 4'(lv);
    e.s.pl = pl;
    e.s.ov = ov;
    q.push_back(e);
  endfunction

  // Monitor: an event is any pulse output high or any change of the status outputs.
  initial begin
    snap_t         got;
    exp_t          e;
    logic [17:0]   st;
    logic [17:0]   prev;
    prev = '1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = {shift_o, correct_input_o, row_clear_o, score_o, misses_o, level_o,
               playing_o, game_over_o};
        st  = {score_o, misses_o, level_o, playing_o, game_over_o};
        if (got.sh || got.co || got.rc || (st != prev)) begin
          prev    = st;
          n_tests = n_tests + 1;
          if (q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_event: cycle %0d snap %h, required no event", cyc, got);
          end else begin
            e = q.pop_front();
            if ((e.cyc != cyc) || (e.s != got)) begin
              n_fail = n_fail + 1;
              $display("FAIL event_c%0d: got cycle %0d snap %h, required cycle %0d snap %h",
                       e.cyc, cyc, got, e.cyc, e.s);
            end
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step();
  endtask

  task automatic press(input logic [3:0] m, input logic [2:0] bl);
    key    = m;
    bottom = bl;
    step();
    key    = 4'd0;
  endtask

  initial begin
    exp_t e;
    step();
    step();
    reset  = 1'b0;
    mon_en = 1'b1;
    exp_ev(2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Start: row_clear at 4, shifts every 8 cycles from 12.
    wait_until(3);
    exp_ev(4,  0, 0, 1, 0, 0, 0, 1, 0);
    exp_ev(12, 1, 0, 0, 0, 0, 0, 1, 0);
    exp_ev(20, 1, 0, 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    wait_until(5);
    start = 1'b0;

    // Hit lane 3.
    wait_until(22);
    exp_ev(23, 0, 1, 0, 1, 0, 0, 1, 0);
    exp_ev(28, 1, 0, 0, 1, 0, 0, 1, 0);
    press(4'b0100, 3'd3);
    bottom = 3'd0;

    // Wrong lane.
    wait_until(30);
    exp_ev(31, 0, 0, 0, 1, 1, 0, 1, 0);
    exp_ev(36, 1, 0, 0, 1, 1, 0, 1, 0);
    press(4'b0001, 3'd3);
    bottom = 3'd0;

    // Hit on the wrap cycle: shift deferred one cycle, level 1, period 6.
    wait_until(43);
    exp_ev(44, 0, 1, 0, 2, 1, 1, 1, 0);
    exp_ev(45, 1, 0, 0, 2, 1, 1, 1, 0);
    exp_ev(50, 1, 0, 0, 2, 1, 1, 1, 0);
    press(4'b0001, 3'd1);
    step();
    bottom = 3'd0;

    // Key during a shift pulse is judged against the next bottom row.
    wait_until(50);
    exp_ev(52, 0, 1, 0, 3, 1, 1, 1, 0);
    exp_ev(56, 1, 0, 0, 3, 1, 1, 1, 0);
    key    = 4'b0010;
    bottom = 3'd0;
    step();
    key    = 4'd0;
    bottom = 3'd2;
    step();
    bottom = 3'd0;

    // Level 2, period 4.
    wait_until(57);
    exp_ev(58, 0, 1, 0, 4, 1, 2, 1, 0);
    exp_ev(60, 1, 0, 0, 4, 1, 2, 1, 0);
    press(4'b1000, 3'd4);
    bottom = 3'd0;

    wait_until(61);
    exp_ev(62, 0, 1, 0, 5, 1, 2, 1, 0);
    exp_ev(64, 1, 0, 0, 5, 1, 2, 1, 0);
    press(4'b0001, 3'd1);
    bottom = 3'd0;

    // Level 3, period clamped at 4.
    wait_until(65);
    exp_ev(66, 0, 1, 0, 6, 1, 3, 1, 0);
    exp_ev(68, 1, 0, 0, 6, 1, 3, 1, 0);
    exp_ev(72, 1, 0, 0, 6, 1, 3, 1, 0);
    press(4'b0010, 3'd2);
    bottom = 3'd0;

    // Two keys at once: a single miss.
    wait_until(73);
    exp_ev(74, 0, 0, 0, 6, 2, 3, 1, 0);
    exp_ev(76, 1, 0, 0, 6, 2, 3, 1, 0);
    press(4'b0011, 3'd1);
    bottom = 3'd0;

    // Fall-off reaches the miss limit, game over, shifts stop.
    wait_until(77);
    exp_ev(80, 1, 0, 0, 6, 3, 3, 1, 0);
    exp_ev(81, 0, 0, 0, 6, 3, 3, 0, 1);
    bottom = 3'd2;

    // Restart from OVER: counters and tempo back to start, three fall-offs end it.
    wait_until(100);
    exp_ev(101, 0, 0, 1, 0, 0, 0, 1, 0);
    exp_ev(109, 1, 0, 0, 0, 1, 0, 1, 0);
    exp_ev(117, 1, 0, 0, 0, 2, 0, 1, 0);
    exp_ev(125, 1, 0, 0, 0, 3, 0, 1, 0);
    exp_ev(126, 0, 0, 0, 0, 3, 0, 0, 1);
    start = 1'b1;
    wait_until(102);
    start = 1'b0;

    // Reset in the middle of a game.
    wait_until(130);
    exp_ev(131, 0, 0, 1, 0, 0, 0, 1, 0);
    start = 1'b1;
    wait_until(132);
    start = 1'b0;
    wait_until(134);
    exp_ev(135, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    wait_until(136);
    reset = 1'b0;
    wait_until(150);

    while (q.size() > 0) begin
      e       = q.pop_front();
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL missing_event: got no event, required cycle %0d snap %h", e.cyc, e.s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
